// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response handshake between the fetch sequencer and imem.
interface fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, runs one outstanding imem fetch at a time,
// applies M-stage redirects and presents fetched instructions to IF/ID.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_ID,
  input  logic                branch_valid,
  input  logic                jalr_M,
  input  logic [31:0]         PC_branch_M,
  input  logic [31:0]         alu_result_M,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         inst_IF,
  output logic [31:0]         PC_IF,
  output logic                inst_valid,
  output logic                flush_IFID,
  output logic                flush_IDEX,
  output logic                fetch_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t           state, state_n;
  logic [31:0]      pc, pc_n;
  logic [31:0]      inst_n, pc_if_n;
  logic             valid_n, err_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             redirect;
  logic [31:0]      target;

  // Branch wins over jalr; targets are always word aligned.
  always_comb begin
    redirect = branch_valid | jalr_M;
    target   = branch_valid ? {PC_branch_M[31:2], 2'b00} : {alu_result_M[31:2], 2'b00};
  end

  // Flushes follow the redirect in the same cycle but are held low during reset.
  assign flush_IFID = rst & redirect;
  assign flush_IDEX = rst & redirect;

  assign imem.req  = (state == S_REQ);
  assign imem.addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state and datapath next values
  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst_IF;
    pc_if_n = PC_IF;
    valid_n = inst_valid;
    cnt_n   = cnt;
    err_n   = fetch_err;

    case (state)
      S_IDLE: state_n = S_REQ;

      S_REQ: begin
        if (redirect) begin
          pc_n = target;
          // A grant that coincides with a redirect fetched the old pc.
          if (imem.gnt) state_n = S_DROP;
        end else if (imem.gnt) begin
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem.rvalid)         cnt_n = '0;
        else if (cnt != MAX_CNT) cnt_n = cnt + CNT_W'(1);
        if (redirect) begin
          pc_n    = target;
          state_n = imem.rvalid ? S_REQ : S_DROP;
        end else if (imem.rvalid) begin
          inst_n  = imem.rdata;
          pc_if_n = pc;
          valid_n = 1'b1;
          state_n = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = target;
          state_n = S_REQ;
        end else if (!stall_ID) begin
          valid_n = 1'b0;
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
      end

      S_DROP: begin
        if (imem.rvalid)         cnt_n = '0;
        else if (cnt != MAX_CNT) cnt_n = cnt + CNT_W'(1);
        if (redirect) pc_n = target;
        if (imem.rvalid) state_n = S_REQ;
      end

      default: state_n = S_IDLE;
    endcase

    // Sticky timeout while a response is outstanding
    if ((state == S_WAIT || state == S_DROP) && cnt_n == MAX_CNT) err_n = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc         <= RESET_PC;
      inst_IF    <= '0;
      PC_IF      <= '0;
      inst_valid <= 1'b0;
      cnt        <= '0;
      fetch_err  <= 1'b0;
    end else begin
      pc         <= pc_n;
      inst_IF    <= inst_n;
      PC_IF      <= pc_if_n;
      inst_valid <= valid_n;
      cnt        <= cnt_n;
      fetch_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a small imem responder.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ID;
  logic        branch_valid;
  logic        jalr_M;
  logic [31:0] PC_branch_M;
  logic [31:0] alu_result_M;
  logic [31:0] inst_IF;
  logic [31:0] PC_IF;
  logic        inst_valid;
  logic        flush_IFID;
  logic        flush_IDEX;
  logic        fetch_err;

  // Responder controls: grant in the request cycle, rvalid once a grant is pending.
  logic        gnt_en;
  logic        rv_en;
  logic        pend;
  logic [31:0] lat_addr;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl_if ifc ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .MAX_WAIT(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_ID     (stall_ID),
    .branch_valid (branch_valid),
    .jalr_M       (jalr_M),
    .PC_branch_M  (PC_branch_M),
    .alu_result_M (alu_result_M),
    .imem         (ifc),
    .inst_IF      (inst_IF),
    .PC_IF        (PC_IF),
    .inst_valid   (inst_valid),
    .flush_IFID   (flush_IFID),
    .flush_IDEX   (flush_IDEX),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
  endfunction

  assign ifc.gnt    = gnt_en & ifc.req;
  assign ifc.rvalid = pend & rv_en;
  assign ifc.rdata  = mem_word(lat_addr);

  always @(posedge clk) begin
    if (!rst) begin
      pend     <= 1'b0;
      lat_addr <= '0;
    end else if (ifc.req && ifc.gnt) begin
      pend     <= 1'b1;
      lat_addr <= ifc.addr;
    end else if (ifc.rvalid) begin
      pend <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!ifc.req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(ifc.req), 32'd1);
  endtask

  // One minimum-latency fetch: request, first-cycle response, presented two cycles after grant.
  task automatic fetch_one(input logic [31:0] exp_pc);
    wait_req();
    chk("imem_addr", ifc.addr, exp_pc);
    tick();
    chk("valid_in_wait", 32'(inst_valid), 32'd0);
    tick();
    chk("inst_valid", 32'(inst_valid), 32'd1);
    chk("PC_IF", PC_IF, exp_pc);
    chk("inst_IF", inst_IF, mem_word(exp_pc));
  endtask

  initial begin
    stall_ID     = 1'b0;
    branch_valid = 1'b0;
    jalr_M       = 1'b0;
    PC_branch_M  = '0;
    alu_result_M = '0;
    gnt_en       = 1'b1;
    rv_en        = 1'b1;
    rst          = 1'b0;
    @(negedge clk);

    // Reset state, flushes masked while reset is asserted
    branch_valid = 1'b1;
    PC_branch_M  = 32'h0000_0040;
    tick();
    chk("rst_req", 32'(ifc.req), 32'd0);
    chk("rst_addr", ifc.addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst_IF, 32'h0);
    chk("rst_pcif", PC_IF, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_flush_ifid", 32'(flush_IFID), 32'd0);
    chk("rst_flush_idex", 32'(flush_IDEX), 32'd0);
    branch_valid = 1'b0;
    rst = 1'b1;

    // Sequential fetch 0,4,8 then C
    for (int i = 0; i < 3; i++) fetch_one(32'(i * 4));
    wait_req();
    chk("seq_addr_c", ifc.addr, 32'h0000_000C);
    chk("seq_err", 32'(fetch_err), 32'd0);

    // Stall holds the instruction in IF/ID
    do_reset();
    stall_ID = 1'b1;
    fetch_one(32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst_IF, 32'h0050_0093);
      chk("stall_pcif", PC_IF, 32'h0);
      chk("stall_req", 32'(ifc.req), 32'd0);
    end
    stall_ID = 1'b0;
    tick();
    chk("unstall_req", 32'(ifc.req), 32'd1);
    chk("unstall_addr", ifc.addr, 32'h4);
    fetch_one(32'h4);

    // Branch while waiting at pc=8: flush, drop stale response, refetch target
    tick();
    chk("pc8_addr", ifc.addr, 32'h8);
    rv_en = 1'b0;
    tick();
    chk("wait8_req", 32'(ifc.req), 32'd0);
    branch_valid = 1'b1;
    PC_branch_M  = 32'h0000_0100;
    #1;
    chk("br_flush_ifid", 32'(flush_IFID), 32'd1);
    chk("br_flush_idex", 32'(flush_IDEX), 32'd1);
    tick();
    branch_valid = 1'b0;
    chk("drop_req", 32'(ifc.req), 32'd0);
    chk("drop_addr", ifc.addr, 32'h100);
    tick();
    chk("drop_hold_req", 32'(ifc.req), 32'd0);
    rv_en = 1'b1;
    tick();
    chk("drop_valid", 32'(inst_valid), 32'd0);
    chk("drop_done_req", 32'(ifc.req), 32'd1);
    fetch_one(32'h100);

    // Branch beats jalr; jalr target low bits cleared
    branch_valid = 1'b1;
    PC_branch_M  = 32'h0000_0200;
    jalr_M       = 1'b1;
    alu_result_M = 32'h0000_0303;
    gnt_en       = 1'b0;
    tick();
    branch_valid = 1'b0;
    chk("prio_addr", ifc.addr, 32'h200);
    tick();
    chk("jalr_addr", ifc.addr, 32'h300);
    chk("jalr_req", 32'(ifc.req), 32'd1);
    jalr_M = 1'b0;
    gnt_en = 1'b1;
    stall_ID = 1'b1;
    fetch_one(32'h300);

    // Redirect overrides a stall in HOLD
    branch_valid = 1'b1;
    PC_branch_M  = 32'h0000_0407;
    tick();
    stall_ID = 1'b0;
    chk("hold_redir_valid", 32'(inst_valid), 32'd0);
    chk("hold_redir_req", 32'(ifc.req), 32'd1);
    chk("hold_redir_addr", ifc.addr, 32'h404);

    // Redirect coinciding with a grant discards that fetch
    PC_branch_M = 32'h0000_0500;
    tick();
    branch_valid = 1'b0;
    chk("req_gnt_drop_req", 32'(ifc.req), 32'd0);
    tick();
    chk("req_gnt_drop_addr", ifc.addr, 32'h500);
    chk("req_gnt_drop_valid", 32'(inst_valid), 32'd0);
    fetch_one(32'h500);

    // pc wraps past 0xFFFF_FFFC
    jalr_M       = 1'b1;
    alu_result_M = 32'hFFFF_FFFC;
    tick();
    jalr_M = 1'b0;
    fetch_one(32'hFFFF_FFFC);
    fetch_one(32'h0);

    // Response timeout sets a sticky error cleared only by reset
    tick();
    chk("to_addr", ifc.addr, 32'h4);
    rv_en = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) tick();
    chk("to_err_early", 32'(fetch_err), 32'd0);
    for (int i = 0; i < 200; i++) tick();
    chk("to_err_set", 32'(fetch_err), 32'd1);
    chk("to_req", 32'(ifc.req), 32'd0);
    rv_en = 1'b1;
    tick();
    chk("to_late_valid", 32'(inst_valid), 32'd1);
    chk("to_late_pcif", PC_IF, 32'h4);
    chk("to_err_sticky", 32'(fetch_err), 32'd1);
    rst = 1'b0;
    tick();
    chk("to_err_clear", 32'(fetch_err), 32'd0);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
